// File: rtl/alu_decoder_unit.sv
// RV32I ALU control decoder: zero-latency ALUControl/illegal plus a one-cycle registered copy.
// Define ALU_DEC_CHECK_EN to add a lookup-table cross-check decode with a sticky mismatch_q flag.
module alu_decoder_unit #(
  parameter logic [2:0] DEFAULT_CTRL = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALUOp,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [2:0] alu_ctrl_q,
  output logic       illegal_q
`ifdef ALU_DEC_CHECK_EN
  ,
  output logic       mismatch_q
`endif
);

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_SLT = 3'b101;

  logic [2:0] alu_ctrl_d;
  logic       illegal_d;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    alu_ctrl_d = DEFAULT_CTRL;
    illegal_d  = 1'b1;
    case (ALUOp)
      2'b00: begin
        alu_ctrl_d = CTRL_ADD;
        illegal_d  = 1'b0;
      end
      2'b01: begin
        alu_ctrl_d = CTRL_SUB;
        illegal_d  = 1'b0;
      end
      2'b10: begin
        illegal_d = 1'b0;
        case (funct3)
          3'b000:  alu_ctrl_d = (op5 && funct7) ? CTRL_SUB : CTRL_ADD;
          3'b010:  alu_ctrl_d = CTRL_SLT;
          3'b110:  alu_ctrl_d = CTRL_OR;
          3'b111:  alu_ctrl_d = CTRL_AND;
          default: begin
            alu_ctrl_d = DEFAULT_CTRL;
            illegal_d  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl_d = DEFAULT_CTRL;
        illegal_d  = 1'b1;
      end
    endcase
  end

  assign ALUControl = alu_ctrl_d;
  assign illegal    = illegal_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ctrl_q <= 3'b000;
      illegal_q  <= 1'b0;
    end else begin
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef ALU_DEC_CHECK_EN
  // Each entry is {illegal, ALUControl}, indexed by {ALUOp, op5, funct3, funct7}.
  typedef logic [127:0][3:0] lut_t;

  function automatic lut_t build_lut();
    lut_t t;
    for (int i = 0; i < 128; i++) begin
      logic [6:0] idx;
      idx  = 7'(i);
      t[i] = {1'b1, DEFAULT_CTRL};
      if (idx[6:5] == 2'b00)      t[i] = {1'b0, CTRL_ADD};
      else if (idx[6:5] == 2'b01) t[i] = {1'b0, CTRL_SUB};
      else if (idx[6:5] == 2'b10) begin
        if (idx[3:1] == 3'b000)      t[i] = {1'b0, (idx[4] & idx[0]) ? CTRL_SUB : CTRL_ADD};
        else if (idx[3:1] == 3'b010) t[i] = {1'b0, CTRL_SLT};
        else if (idx[3:1] == 3'b110) t[i] = {1'b0, CTRL_OR};
        else if (idx[3:1] == 3'b111) t[i] = {1'b0, CTRL_AND};
      end
    end
    return t;
  endfunction

  localparam lut_t DEC_LUT = build_lut();

  logic [3:0] lut_word;
  logic       mismatch_d;

  assign lut_word   = DEC_LUT[{ALUOp, op5, funct3, funct7}];
  assign mismatch_d = mismatch_q | (lut_word != {illegal_d, alu_ctrl_d});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mismatch_q <= 1'b0;
    else       mismatch_q <= mismatch_d;
  end
`endif

endmodule

// File: tb/tb_alu_decoder_unit.sv
// Scoreboard bench for alu_decoder_unit: random/exhaustive decode, registered latency, async reset.
module tb_alu_decoder_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ALUOp;
  logic       op5;
  logic [2:0] funct3;
  logic       funct7;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [2:0] alu_ctrl_q;
  logic       illegal_q;
`ifdef ALU_DEC_CHECK_EN
  logic       mismatch_q;
`endif

  alu_decoder_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ALUOp      (ALUOp),
    .op5        (op5),
    .funct3     (funct3),
    .funct7     (funct7),
    .ALUControl (ALUControl),
    .illegal    (illegal),
    .alu_ctrl_q (alu_ctrl_q),
    .illegal_q  (illegal_q)
`ifdef ALU_DEC_CHECK_EN
    ,
    .mismatch_q (mismatch_q)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0] sb_q[$];

  // Reference: ALUOp=10 operations by funct3 (code, legal).
  logic [2:0] ri_code  [8] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
  bit         ri_legal [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic [3:0] ref_dec(logic [1:0] a, logic o5, logic [2:0] f3, logic f7);
    if (a == 2'd0) return 4'b0_000;
    if (a == 2'd1) return 4'b0_001;
    if (a == 2'd3) return 4'b1_000;
    if (f3 == 3'd0) return (o5 && f7) ? 4'b0_001 : 4'b0_000;
    if (ri_legal[f3]) return {1'b0, ri_code[f3]};
    return 4'b1_000;
  endfunction

  task automatic check(string name, logic [7:0] actual, logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive on the falling edge, check the combinational decode, queue the registered expectation.
  task automatic apply(logic [1:0] a, logic o5, logic [2:0] f3, logic f7);
    logic [3:0] exp_v;
    @(negedge clk);
    ALUOp = a; op5 = o5; funct3 = f3; funct7 = f7;
    exp_v = ref_dec(a, o5, f3, f7);
    sb_q.push_back(exp_v);
    #1;
    check("comb_ctrl", 8'(ALUControl), 8'(exp_v[2:0]));
    check("comb_illegal", 8'(illegal), 8'(exp_v[3]));
  endtask

  // Monitor: every edge outside reset presents a registered result; compare it with the queue head.
  always @(posedge clk) begin
    #1;
    if (!reset && sb_q.size() > 0) begin
      logic [3:0] e;
      e = sb_q.pop_front();
      check("reg_ctrl", 8'(alu_ctrl_q), 8'(e[2:0]));
      check("reg_illegal", 8'(illegal_q), 8'(e[3]));
    end
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ALUOp = 2'b11; op5 = 1'b0; funct3 = 3'b000; funct7 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 8'(alu_ctrl_q), 8'd0);
    check("reset_illegal", 8'(illegal_q), 8'd0);
    check("reset_comb_illegal", 8'(illegal), 8'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      apply(v[6:5], v[4], v[3:1], v[0]);
    end
    for (int i = 0; i < 100; i++)
      apply(2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), 1'($urandom));

    apply(2'b10, 1'b1, 3'b000, 1'b1);
    apply(2'b10, 1'b0, 3'b000, 1'b1);
    apply(2'b10, 1'b1, 3'b000, 1'b0);
    apply(2'b10, 1'b0, 3'b101, 1'b1);

    // Value applied before edge N must not appear on alu_ctrl_q until after edge N.
    apply(2'b11, 1'b1, 3'b111, 1'b1);
    apply(2'b01, 1'b0, 3'b000, 1'b0);
    check("latency_before_ctrl", 8'(alu_ctrl_q), 8'd0);
    check("latency_before_illegal", 8'(illegal_q), 8'd1);
    @(posedge clk);
    #3;
    check("latency_after_ctrl", 8'(alu_ctrl_q), 8'd1);

    // Mid-cycle asynchronous reset with alu_ctrl_q=001 held.
    reset = 1'b1;
    #1;
    check("async_reset_ctrl", 8'(alu_ctrl_q), 8'd0);
    check("async_reset_comb", 8'(ALUControl), 8'd1);
    @(negedge clk);
    reset = 1'b0;

    // Mid-cycle asynchronous reset with illegal_q=1 held.
    apply(2'b11, 1'b0, 3'b010, 1'b0);
    @(posedge clk);
    #3;
    check("illegal_held", 8'(illegal_q), 8'd1);
    reset = 1'b1;
    #1;
    check("async_reset_illegal", 8'(illegal_q), 8'd0);
    check("async_reset_comb_illegal", 8'(illegal), 8'd1);
    @(negedge clk);
    reset = 1'b0;

    apply(2'b10, 1'b1, 3'b110, 1'b0);
    apply(2'b10, 1'b0, 3'b111, 1'b1);
    drain();

`ifdef ALU_DEC_CHECK_EN
    check("mismatch_clean", 8'(mismatch_q), 8'd0);
    force dut.lut_word = 4'b1111;
    apply(2'b00, 1'b0, 3'b000, 1'b0);
    check("mismatch_before_edge", 8'(mismatch_q), 8'd0);
    @(posedge clk);
    #3;
    check("mismatch_set", 8'(mismatch_q), 8'd1);
    release dut.lut_word;
    apply(2'b10, 1'b0, 3'b010, 1'b0);
    @(posedge clk);
    #3;
    check("mismatch_sticky", 8'(mismatch_q), 8'd1);
    reset = 1'b1;
    #1;
    check("mismatch_reset", 8'(mismatch_q), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
